// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the eLC-3 control unit: state encoding, opcodes,
// mux-select codes and the per-state control-word decode.
package lc3_ctrl_pkg;

  // Codes 32/33/35 do not fit in 5 bits, so they sit in unused slots.
  typedef enum logic [4:0] {
    S0     = 5'd0,
    S1     = 5'd1,
    S32    = 5'd2,
    S33    = 5'd3,
    S4     = 5'd4,
    S5     = 5'd5,
    S6     = 5'd6,
    S7     = 5'd7,
    S35    = 5'd8,
    S9     = 5'd9,
    S12    = 5'd12,
    S16    = 5'd16,
    S18    = 5'd18,
    S21    = 5'd21,
    S22    = 5'd22,
    S23    = 5'd23,
    S25    = 5'd25,
    S27    = 5'd27,
    PAUSE1 = 5'd28,
    PAUSE2 = 5'd29,
    HALTED = 5'd30
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic       ADDR1_PC    = 1'b0;
  localparam logic       ADDR1_SR1   = 1'b1;
  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_SEXT6 = 2'd1;
  localparam logic [1:0] ADDR2_SEXT9 = 2'd2;
  localparam logic [1:0] ADDR2_SEXT11 = 2'd3;
  localparam logic [1:0] PCMUX_INC   = 2'd0;
  localparam logic [1:0] PCMUX_ADDR  = 2'd2;
  localparam logic [1:0] DRMUX_R7    = 2'd1;
  localparam logic [1:0] SR1MUX_IR11 = 2'd0;
  localparam logic [1:0] SR1MUX_IR8  = 2'd1;
  localparam logic [1:0] MARMUX_ADDR = 2'd1;
  localparam logic [1:0] ALUK_ADD    = 2'd0;
  localparam logic [1:0] ALUK_AND    = 2'd1;
  localparam logic [1:0] ALUK_NOT    = 2'd2;
  localparam logic [1:0] ALUK_PASS   = 2'd3;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic       addr1mux;
    logic [1:0] addr2mux, pcmux, drmux, sr1mux, sr2mux, marmux, aluk;
    logic       mio_en, mem_oe, mem_we;
  } ctrl_t;

  function automatic logic is_wait(state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

  // Control word for state s. last_wait marks the final cycle of a RAM
  // access; ir5 selects the immediate operand for ADD/AND.
  function automatic ctrl_t ctrl_decode(state_t s, logic last_wait, logic ir5);
    ctrl_t c;
    c = '0;
    case (s)
      S18: begin
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PCMUX_INC; c.ld_pc = 1'b1;
      end
      S33, S25: begin
        c.mem_oe = 1'b1; c.mio_en = 1'b1; c.ld_mdr = last_wait;
      end
      S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      S32: c.ld_ben = 1'b1;
      S1, S5, S9: begin
        c.sr1mux   = SR1MUX_IR8;
        c.sr2mux   = (s == S9) ? 2'd0 : {1'b0, ir5};
        c.aluk     = (s == S1) ? ALUK_ADD : (s == S5) ? ALUK_AND : ALUK_NOT;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      S22: begin
        c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_SEXT9;
        c.pcmux = PCMUX_ADDR; c.ld_pc = 1'b1;
      end
      S12: begin
        c.sr1mux = SR1MUX_IR8; c.addr1mux = ADDR1_SR1; c.addr2mux = ADDR2_ZERO;
        c.pcmux = PCMUX_ADDR; c.ld_pc = 1'b1;
      end
      S4: begin c.drmux = DRMUX_R7; c.gate_pc = 1'b1; c.ld_reg = 1'b1; end
      S21: begin
        c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_SEXT11;
        c.pcmux = PCMUX_ADDR; c.ld_pc = 1'b1;
      end
      S6, S7: begin
        c.sr1mux = SR1MUX_IR8; c.addr1mux = ADDR1_SR1; c.addr2mux = ADDR2_SEXT6;
        c.marmux = MARMUX_ADDR; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
      end
      S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      S23: begin
        c.sr1mux = SR1MUX_IR11; c.aluk = ALUK_PASS; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
      end
      S16: c.mem_we = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lc3_control_unit_mem_wait_counter.sv
// RAM wait-state counter.
//   clk_i/rst_i : clock, asynchronous active-high reset
//   en_i        : count this cycle
//   clr_i       : return to zero (wins over en_i)
//   done_o      : current count is the last wait cycle (MEM_WAIT-1)
//   done_next_o : the count being loaded will be the last wait cycle
module mem_wait_counter #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic done_o,
  output logic done_next_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o      = (cnt_q == LAST);
  assign done_next_o = (cnt_d == LAST);

endmodule

// File: rtl/lc3_control_unit.sv
// eLC-3 Moore control FSM: fetch / decode / execute sequencing with
// MEM_WAIT-cycle RAM accesses.
//   Inputs : Clk, Reset (async, active-high), Run, Continue, IR_15_12, IR_5, BEN
//   Outputs: register loads, bus gates, mux selects, ALUK, MIO_EN,
//            Mem_OE/Mem_WE strobes and the State code for display.
// The control word is registered together with the state, so outputs only
// change on the clock edge (or clear on Reset).
module lc3_control_unit
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] IR_15_12,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_REG,
  output logic       LD_CC,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] PCMUX,
  output logic [1:0] DRMUX,
  output logic [1:0] SR1MUX,
  output logic [1:0] SR2MUX,
  output logic [1:0] MARMUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] State
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   wait_done, wait_done_next, cnt_en, wait_last_d;

  // Count while in a wait state; clear on the exit cycle and elsewhere.
  assign cnt_en = is_wait(state_q);

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) u_wait (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .en_i        (cnt_en),
    .clr_i       (!cnt_en || wait_done),
    .done_o      (wait_done),
    .done_next_o (wait_done_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED: if (Run) state_d = S18;
      S18:    state_d = S33;
      S33:    if (wait_done) state_d = S35;
      S35:    state_d = S32;
      S32: begin
        case (IR_15_12)
          OP_ADD:   state_d = S1;
          OP_AND:   state_d = S5;
          OP_NOT:   state_d = S9;
          OP_BR:    state_d = S0;
          OP_JMP:   state_d = S12;
          OP_JSR:   state_d = S4;
          OP_LDR:   state_d = S6;
          OP_STR:   state_d = S7;
          OP_PAUSE: state_d = PAUSE1;
          default:  state_d = S18;
        endcase
      end
      S0:     state_d = BEN ? S22 : S18;
      S4:     state_d = S21;
      S6:     state_d = S25;
      S25:    if (wait_done) state_d = S27;
      S7:     state_d = S23;
      S23:    state_d = S16;
      S16:    if (wait_done) state_d = S18;
      PAUSE1: if (Continue) state_d = PAUSE2;
      PAUSE2: if (!Continue) state_d = S18;
      default: state_d = S18;
    endcase
  end

  // The registered control word for the next state needs to know whether
  // that state will be the final cycle of its RAM access.
  assign wait_last_d = is_wait(state_d) && wait_done_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= HALTED;
      ctrl_q  <= '0;
    end else begin
      // NOTE: non-blocking so state and control word update together from
      // the same pre-edge values.
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d, wait_last_d, IR_5);
    end
  end

  assign LD_MAR     = ctrl_q.ld_mar;
  assign LD_MDR     = ctrl_q.ld_mdr;
  assign LD_IR      = ctrl_q.ld_ir;
  assign LD_BEN     = ctrl_q.ld_ben;
  assign LD_REG     = ctrl_q.ld_reg;
  assign LD_CC      = ctrl_q.ld_cc;
  assign LD_PC      = ctrl_q.ld_pc;
  assign GatePC     = ctrl_q.gate_pc;
  assign GateMDR    = ctrl_q.gate_mdr;
  assign GateALU    = ctrl_q.gate_alu;
  assign GateMARMUX = ctrl_q.gate_marmux;
  assign ADDR1MUX   = ctrl_q.addr1mux;
  assign ADDR2MUX   = ctrl_q.addr2mux;
  assign PCMUX      = ctrl_q.pcmux;
  assign DRMUX      = ctrl_q.drmux;
  assign SR1MUX     = ctrl_q.sr1mux;
  assign SR2MUX     = ctrl_q.sr2mux;
  assign MARMUX     = ctrl_q.marmux;
  assign ALUK       = ctrl_q.aluk;
  assign MIO_EN     = ctrl_q.mio_en;
  assign Mem_OE     = ctrl_q.mem_oe;
  assign Mem_WE     = ctrl_q.mem_we;
  assign State      = state_q;

endmodule

// File: doc/lc3_control_unit.md
Name: lc3_control_unit

Overview:
- Moore control FSM that sequences the eLC-3 datapath through fetch, decode and execute.
- Drives every datapath load, gate and mux-select line, plus the RAM enables.
- Inserts a configurable number of memory wait cycles on every RAM access.
- Sits beside the datapath in the top level. Consumes IR_15_12, IR_5, BEN and the user Run/Continue inputs.

Parameters:
- MEM_WAIT, 2, cycles each RAM read/write state is held (min 1).
- CNT_W, 4, width of the wait counter. Must satisfy MEM_WAIT < 2**CNT_W.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- Run  in  1  level; leaves HALTED.
- Continue  in  1  level; releases PAUSE.
- IR_15_12  in  4  opcode.
- IR_5  in  1  immediate-mode bit.
- BEN  in  1  registered branch enable.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  out  1 each  register loads.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high in any cycle.
- ADDR1MUX  out  1  0=PC, 1=SR1.
- ADDR2MUX  out  2  0=zero, 1=SEXT6, 2=SEXT9, 3=SEXT11.
- PCMUX  out  2  0=PC+1, 1=Bus, 2=ADDR.
- DRMUX  out  2  0=IR[11:9], 1=R7.
- SR1MUX  out  2  0=IR[11:9], 1=IR[8:6].
- SR2MUX  out  2  0=SR2, 1=SEXT5 (bit 0 used).
- MARMUX  out  2  0=ZEXT8, 1=ADDR.
- ALUK  out  2  0=ADD, 1=AND, 2=NOT A, 3=PASS A.
- MIO_EN  out  1  MDR loads from RAM.
- Mem_OE, Mem_WE  out  1 each  RAM read / write strobes, active-high.
- State  out  5  current state encoding, for debug display.

Behaviour:
- Reset:
  - State=HALTED, wait counter=0.
  - All outputs 0 while Reset is high and in HALTED.
- Outputs are a pure function of state; no input-to-output combinational path. Every output not listed for a state is 0.
- Fetch sequence:
  - HALTED: Run=1 -> S18.
  - S18: GatePC, LD_MAR, PCMUX=0, LD_PC -> S33.
  - S33 (read wait): Mem_OE, MIO_EN. LD_MDR only on the final wait cycle (cnt==MEM_WAIT-1) -> S35.
  - S35: GateMDR, LD_IR -> S32.
  - S32: LD_BEN; decode on IR_15_12.
- Decode targets (opcode -> state):
  - 0001 ADD -> S1. SR1MUX=1, SR2MUX=IR_5, ALUK=0, GateALU, LD_REG, LD_CC.
  - 0101 AND -> S5. As S1 with ALUK=1.
  - 1001 NOT -> S9. ALUK=2, otherwise as S1 without SR2MUX.
  - 0000 BR -> S0. BEN=1 -> S22 (ADDR1MUX=0, ADDR2MUX=2, PCMUX=2, LD_PC); BEN=0 -> S18.
  - 1100 JMP -> S12. SR1MUX=1, ADDR1MUX=1, ADDR2MUX=0, PCMUX=2, LD_PC.
  - 0100 JSR -> S4. DRMUX=1, GatePC, LD_REG -> S21.
  - S21: ADDR1MUX=0, ADDR2MUX=3, PCMUX=2, LD_PC.
  - 0110 LDR -> S6. SR1MUX=1, ADDR1MUX=1, ADDR2MUX=1, MARMUX=1, GateMARMUX, LD_MAR -> S25.
  - S25 (read wait, as S33) -> S27.
  - S27: GateMDR, LD_REG, LD_CC.
  - 0111 STR -> S7. Same outputs as S6 -> S23.
  - S23: SR1MUX=0, ALUK=3, GateALU, LD_MDR -> S16.
  - S16 (write wait): Mem_WE held MEM_WAIT cycles.
  - 1101 PAUSE -> PAUSE1 (wait Continue=1) -> PAUSE2 (wait Continue=0) -> S18.
  - Any other opcode -> S18 (treated as NOP).
- Every execute path ends -> S18; fetch never returns to HALTED.
- Wait counter:
  - Increments in S33/S25/S16.
  - Clears to 0 on exit and in every other state.
  - Exit occurs when cnt==MEM_WAIT-1, so each access takes exactly MEM_WAIT cycles.
  - MEM_WAIT=1 gives a single cycle with LD_MDR (read) or Mem_WE (write).
- Mem_OE and Mem_WE are never high together.
- Run is ignored outside HALTED. Continue is ignored outside PAUSE.
- Reset mid-access: outputs drop to 0 immediately (asynchronous), counter clears, next state HALTED.
- Latencies (MEM_WAIT=W):
  - Fetch+decode: 3+W cycles.
  - ADD/AND/NOT: +1.
  - LDR: +2+W.
  - STR: +2+W.
  - BR taken: +2; not taken: +1.
  - JSR: +2.

Decomposition:
- Package lc3_ctrl_pkg:
  - state_t enum with fixed 5-bit codes, e.g. S18=5'd18, HALTED=5'd30, PAUSE1=5'd28, PAUSE2=5'd29.
  - Opcode constants (OP_ADD etc.).
  - Mux-select and ALUK localparams.
- One sub-module, mem_wait_counter. Counter with enable, clear and done = (cnt==MEM_WAIT-1).
- FSM next-state and output decode stay in lc3_control_unit.

Test Plan:
- Reset during S33 with Mem_OE=1 -> Mem_OE=0 within the same cycle. After Reset drops, State=30 and all outputs 0 until Run=1.
- Run=1, MEM_WAIT=2, instruction 16'h1262 (ADD R1,R1,#2):
  - S18, S33, S33, S35, S32, S1 on consecutive cycles.
  - LD_MDR only on the 2nd S33.
  - In S1: SR2MUX=1, GateALU=1, LD_REG=1, LD_CC=1.
- BR with BEN=1 -> S0, S22 with PCMUX=2, ADDR2MUX=2, LD_PC=1. With BEN=0 -> S0, S18.
- STR (0111) -> S7, S23, S16 for exactly MEM_WAIT cycles with Mem_WE=1, Mem_OE=0, MIO_EN=0.
- PAUSE (1101):
  - Holds PAUSE1 for 10 cycles with Continue=0.
  - Continue=1 -> PAUSE2, held until Continue=0, then S18.
- Opcode 1111 -> S32 then S18. No LD_REG/LD_PC asserted.
- Every cycle of all tests: at most one Gate* high, Mem_OE & Mem_WE never both high.
